// File: rtl/nios_system_onchip_mem_stream_reader_if.sv
// Bus bundle for the on-chip memory stream reader.
// Carries the Avalon-MM read-master signals toward the RAM s1 port and the
// valid/ready output stream toward the sink.
//   master : the reader (drives mem_* requests and the out_* stream)
//   slave  : the RAM plus stream sink (drives mem_readdata and out_ready)
interface nios_system_onchip_mem_stream_reader_if #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 16
);
  logic [ADDR_W-1:0]   mem_address;
  logic                mem_chipselect;
  logic                mem_write;
  logic [DATA_W/8-1:0] mem_byteenable;
  logic                mem_clken;
  logic [DATA_W-1:0]   mem_readdata;
  logic [DATA_W-1:0]   out_data;
  logic                out_valid;
  logic                out_ready;
  logic                out_last;

  modport master (
    output mem_address, mem_chipselect, mem_write, mem_byteenable, mem_clken,
    output out_data, out_valid, out_last,
    input  mem_readdata, out_ready
  );

  modport slave (
    input  mem_address, mem_chipselect, mem_write, mem_byteenable, mem_clken,
    input  out_data, out_valid, out_last,
    output mem_readdata, out_ready
  );
endinterface

// File: rtl/nios_system_onchip_mem_stream_reader.sv
// Avalon-MM read master that drains a block of words from the on-chip RAM
// (1-cycle read latency) and presents them as a valid/ready stream through a
// small FIFO, so reads run back-to-back while the sink keeps up.
// Ports:
//   clk, reset          : clock, asynchronous active-high reset
//   start, abort        : begin a transfer / cancel it and flush
//   base_addr, length   : first word address and word count (sampled on start)
//   busy, done          : transfer in progress / 1-cycle completion pulse
//   bus (master)        : mem_* read requests + mem_readdata, out_* stream
module nios_system_onchip_mem_stream_reader #(
  parameter int ADDR_W     = 13,
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   length,
  output logic              busy,
  output logic              done,
  nios_system_onchip_mem_stream_reader_if.master bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   remaining_q, remaining_d;
  logic              inflight_q, inflight_d;
  logic              inflight_last_q, inflight_last_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  fifo_count_q, fifo_count_d;
  logic [DATA_W-1:0] fifo_data_q [FIFO_DEPTH];
  logic              fifo_last_q [FIFO_DEPTH];

  logic              issue, flush, push, pop, out_valid, head_last, credit;
  logic [CNT_W:0]    occupancy;

  // Buffered words plus the one possibly in flight must leave room for the
  // word this cycle's issue will return, since capture never stalls.
  assign occupancy = {1'b0, fifo_count_q} + {{CNT_W{1'b0}}, inflight_q};
  assign credit    = occupancy < (CNT_W+1)'(FIFO_DEPTH);
  assign out_valid = fifo_count_q != '0;
  assign head_last = fifo_last_q[rd_ptr_q];
  assign pop       = out_valid & bus.out_ready;
  assign push      = inflight_q & ~flush;

  always_comb begin
    state_d         = state_q;
    addr_d          = addr_q;
    remaining_d     = remaining_q;
    issue           = 1'b0;
    flush           = abort;
    case (state_q)
      S_IDLE: begin
        if (!abort && start) begin
          addr_d      = base_addr;
          remaining_d = length;
          state_d     = (length == '0) ? S_DONE : S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (credit) begin
          issue       = 1'b1;
          addr_d      = addr_q + ADDR_W'(1);
          remaining_d = remaining_q - (ADDR_W+1)'(1);
          if (remaining_q == (ADDR_W+1)'(1)) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (abort) state_d = S_IDLE;
        else if (pop && head_last) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase

    inflight_d      = issue;
    inflight_last_d = issue && (remaining_q == (ADDR_W+1)'(1));

    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    fifo_count_d = fifo_count_q;
    if (flush) begin
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      fifo_count_d = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_count_d = fifo_count_q + CNT_W'(1);
        2'b01:   fifo_count_d = fifo_count_q - CNT_W'(1);
        default: fifo_count_d = fifo_count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= S_IDLE;
      addr_q          <= '0;
      remaining_q     <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      fifo_count_q    <= '0;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      remaining_q     <= remaining_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      fifo_count_q    <= fifo_count_d;
    end
  end

  // FIFO storage needs no reset: entries are only visible through out_valid.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data_q[wr_ptr_q] <= bus.mem_readdata;
      fifo_last_q[wr_ptr_q] <= inflight_last_q;
    end
  end

  assign busy               = (state_q == S_ISSUE) || (state_q == S_DRAIN);
  assign done               = (state_q == S_DONE);
  assign bus.mem_address    = addr_q;
  assign bus.mem_chipselect = issue;
  assign bus.mem_write      = 1'b0;
  assign bus.mem_byteenable = '1;
  assign bus.mem_clken      = 1'b1;
  assign bus.out_valid      = out_valid;
  // Gate the head with valid so the stream reads zero whenever it is empty.
  assign bus.out_data       = out_valid ? fifo_data_q[rd_ptr_q] : '0;
  assign bus.out_last       = out_valid & head_last;
endmodule

// File: tb/tb_nios_system_onchip_mem_stream_reader.sv
// Self-checking bench for the on-chip memory stream reader: RAM model,
// transfer-level reference model and per-cycle compare process.
module tb_nios_system_onchip_mem_stream_reader;
  localparam int ADDR_W = 13;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              start, abort;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W:0]   length;
  logic              busy, done;

  nios_system_onchip_mem_stream_reader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  nios_system_onchip_mem_stream_reader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .base_addr(base_addr), .length(length), .busy(busy), .done(done),
    .bus(bus.master)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM: 1-cycle read latency
  logic [DATA_W-1:0] ram [1 << ADDR_W];
  always @(posedge clk) if (bus.mem_chipselect) bus.mem_readdata <= ram[bus.mem_address];

  // Sink ready driver
  int  ready_mode = 0;   // 0: ready_val, 1: random
  bit  ready_val  = 1'b1;
  always begin
    bus.out_ready = (ready_mode == 1) ? ($urandom_range(0, 1) == 1) : ready_val;
    @(posedge clk);
    #1;
  end

  // Reference model state
  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] got_q[$];
  int                got_cyc[$];
  logic [ADDR_W-1:0] addr_log[$];
  logic [ADDR_W-1:0] next_addr;
  int  issues_left = 0, outstanding = 0, max_outstanding = 0;
  bit  active = 0, done_seen = 0;
  int  done_cyc = 0, start_cyc = 0;
  bit  prev_stall = 0;
  logic [DATA_W-1:0] prev_data;
  logic prev_last;

  task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete(); issues_left = 0; outstanding = 0; active = 0; prev_stall = 0;
    end else begin
      chk(bus.mem_write == 1'b0 && bus.mem_byteenable == 2'b11 && bus.mem_clken == 1'b1,
          "static_bus", {bus.mem_write, bus.mem_byteenable, bus.mem_clken}, 4'b0111);
      if (prev_stall)
        chk(bus.out_valid && bus.out_data == prev_data && bus.out_last == prev_last,
            "stall_stable", {bus.out_valid, bus.out_data}, {1'b1, prev_data});
      if (bus.out_valid)
        chk(exp_q.size() > 0, "valid_without_word", bus.out_data, 0);
      if (bus.out_valid && bus.out_ready && exp_q.size() > 0) begin
        chk(bus.out_data == exp_q[0], "out_data", bus.out_data, exp_q[0]);
        chk(bus.out_last == (exp_q.size() == 1), "out_last", bus.out_last, exp_q.size() == 1);
        got_q.push_back(bus.out_data);
        got_cyc.push_back(cyc);
        void'(exp_q.pop_front());
        outstanding--;
      end
      if (bus.mem_chipselect) begin
        chk(active && issues_left > 0 && bus.mem_address == next_addr, "mem_address",
            bus.mem_address, next_addr);
        addr_log.push_back(bus.mem_address);
        next_addr = next_addr + 1'b1;
        issues_left--;
        outstanding++;
        if (outstanding > max_outstanding) max_outstanding = outstanding;
        chk(outstanding <= DEPTH, "outstanding_bound", outstanding, DEPTH);
      end
      if (done) begin
        chk(active && exp_q.size() == 0 && issues_left == 0 && !busy, "done_pulse",
            {active, busy, 16'(exp_q.size())}, 18'h20000);
        active = 0; done_seen = 1; done_cyc = cyc;
      end
      if (abort) begin
        exp_q.delete(); issues_left = 0; outstanding = 0; active = 0;
      end
      prev_stall = bus.out_valid && !bus.out_ready && !abort;
      prev_data  = bus.out_data;
      prev_last  = bus.out_last;
    end
  end

  task automatic do_start(input logic [ADDR_W-1:0] b, input logic [ADDR_W:0] l);
    @(posedge clk); #1;
    start = 1'b1; base_addr = b; length = l; start_cyc = cyc;
    exp_q.delete(); got_q.delete(); got_cyc.delete(); addr_log.delete();
    for (int i = 0; i < int'(l); i++) exp_q.push_back(ram[b + ADDR_W'(i)]);
    next_addr = b; issues_left = int'(l); outstanding = 0; max_outstanding = 0;
    active = 1; done_seen = 0;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int maxc);
    for (int i = 0; i < maxc && !done_seen; i++) @(posedge clk);
    chk(done_seen, "done_timeout", done_seen, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0; base_addr = '0; length = '0;
    for (int i = 0; i < (1 << ADDR_W); i++) ram[i] = 16'(i * 3);
    repeat (3) @(posedge clk);
    #1;
    chk({busy, done, bus.out_valid, bus.out_last, bus.out_data, bus.mem_address, bus.mem_chipselect} == '0,
        "reset_outputs", {busy, done, bus.out_valid, bus.mem_chipselect}, 0);
    reset = 1'b0;

    // 1: back-to-back throughput and latency
    do_start(13'h0010, 14'd4);
    wait_done(50);
    $display("T1 base=0x0010 len=4 words=%0d", got_q.size());
    chk(got_q.size() == 4, "t1_count", got_q.size(), 4);
    if (got_q.size() == 4) begin
      chk(got_q[0] == 16'h0030, "t1_w0", got_q[0], 16'h0030);
      chk(got_q[1] == 16'h0033, "t1_w1", got_q[1], 16'h0033);
      chk(got_q[2] == 16'h0036, "t1_w2", got_q[2], 16'h0036);
      chk(got_q[3] == 16'h0039, "t1_w3", got_q[3], 16'h0039);
      chk(got_cyc[0] == start_cyc + 3, "t1_first_latency", got_cyc[0] - start_cyc, 3);
      chk(got_cyc[3] == start_cyc + 6, "t1_last_cycle", got_cyc[3] - start_cyc, 6);
    end
    chk(done_cyc == start_cyc + 7, "t1_done_cycle", done_cyc - start_cyc, 7);

    for (int i = 0; i < (1 << ADDR_W); i++) ram[i] = 16'($urandom);

    // 2: address wrap
    do_start(13'h1FFE, 14'd4);
    wait_done(50);
    $display("T2 base=0x1FFE len=4 issues=%0d", addr_log.size());
    chk(addr_log.size() == 4, "t2_issues", addr_log.size(), 4);
    if (addr_log.size() == 4) begin
      chk(addr_log[0] == 13'h1FFE, "t2_a0", addr_log[0], 13'h1FFE);
      chk(addr_log[1] == 13'h1FFF, "t2_a1", addr_log[1], 13'h1FFF);
      chk(addr_log[2] == 13'h0000, "t2_a2", addr_log[2], 0);
      chk(addr_log[3] == 13'h0001, "t2_a3", addr_log[3], 1);
    end

    // 3: backpressure window, ready low cycles 3..10 after start
    do_start(13'h0100, 14'd8);
    for (int k = 2; k < 60; k++) begin
      @(posedge clk);
      ready_val = !(k >= 3 && k <= 10);
    end
    ready_val = 1'b1;
    $display("T3 len=8 backpressure words=%0d max_outstanding=%0d", got_q.size(), max_outstanding);
    chk(done_seen, "t3_done", done_seen, 1);
    chk(got_q.size() == 8, "t3_count", got_q.size(), 8);
    chk(max_outstanding == DEPTH, "t3_max_outstanding", max_outstanding, DEPTH);

    // 4: zero length
    do_start(13'h0200, 14'd0);
    wait_done(10);
    $display("T4 len=0 done_after=%0d", done_cyc - start_cyc);
    chk(done_cyc == start_cyc + 1, "t4_done_cycle", done_cyc - start_cyc, 1);
    chk(addr_log.size() == 0 && got_q.size() == 0, "t4_no_activity", addr_log.size() + got_q.size(), 0);

    // 5: abort after 5 words, then a short transfer
    do_start(13'h0300, 14'd16);
    for (int i = 0; i < 100 && got_q.size() < 5; i++) @(posedge clk);
    #1; abort = 1'b1;
    @(posedge clk); #1; abort = 1'b0;
    chk(!bus.out_valid && !busy, "t5_abort_clear", {bus.out_valid, busy}, 0);
    repeat (20) @(posedge clk);
    chk(!done_seen, "t5_no_done", done_seen, 0);
    do_start(13'h0400, 14'd2);
    wait_done(50);
    $display("T5 abort then len=2 words=%0d", got_q.size());
    chk(got_q.size() == 2, "t5_count", got_q.size(), 2);

    // 6: reset while draining
    ready_val = 1'b0;
    do_start(13'h0500, 14'd3);
    for (int i = 0; i < 50 && issues_left > 0; i++) @(posedge clk);
    repeat (2) @(posedge clk);
    #1; reset = 1'b1;
    #1;
    chk({busy, done, bus.out_valid, bus.out_last, bus.out_data, bus.mem_address, bus.mem_chipselect} == '0,
        "t6_reset_outputs", {busy, done, bus.out_valid, bus.mem_chipselect}, 0);
    @(posedge clk); #1; reset = 1'b0; ready_val = 1'b1;
    do_start(13'h0600, 14'd5);
    wait_done(50);
    $display("T6 reset mid-drain then len=5 words=%0d", got_q.size());
    chk(got_q.size() == 5, "t6_count", got_q.size(), 5);

    // 7: random transfers with random backpressure
    ready_mode = 1;
    for (int t = 0; t < 12; t++) begin
      logic [ADDR_W-1:0] b;
      logic [ADDR_W:0]   l;
      b = ADDR_W'($urandom);
      l = (ADDR_W+1)'($urandom_range(1, 40));
      do_start(b, l);
      wait_done(400);
      $display("T7.%0d base=0x%04h len=%0d words=%0d", t, b, l, got_q.size());
      chk(got_q.size() == int'(l), "t7_count", got_q.size(), l);
    end
    ready_mode = 0;

    // 8: whole memory with wrap
    do_start(13'h1234, 14'h2000);
    wait_done(9000);
    $display("T8 base=0x1234 len=8192 words=%0d", got_q.size());
    chk(got_q.size() == 8192, "t8_count", got_q.size(), 8192);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
